// File: rtl/ws2812b_pkg.sv
// Shared types and constants for the ws2812b strip controller.
package ws2812b_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD       = 2'd1,
    SEND       = 2'd2,
    WAIT_LATCH = 2'd3
  } state_t;

  localparam int PIXEL_W = 24;
  localparam int CHAN_W  = 8;

  // Channel bit offsets inside a GRB pixel (bit 23 goes out on the wire first)
  localparam int G_HI = 23;
  localparam int G_LO = 16;
  localparam int R_HI = 15;
  localparam int R_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  // Scale one colour channel by factor (1..256) and drop the low byte.
  // 255 * 256 = 65280 still fits in 16 bits, so no overflow is possible.
  function automatic logic [CHAN_W-1:0] scale_chan(input logic [CHAN_W-1:0] chan,
                                                   input logic [CHAN_W:0]   factor);
    return 8'((16'(chan) * 16'(factor)) >> 8);
  endfunction

endpackage

// File: rtl/ws2812b_pixel_scale.sv
// Combinational per-channel brightness scaling: c' = (c * (scale + 1)) >> 8.
// Only instantiated when WS2812B_BRIGHTNESS_EN is defined.
module ws2812b_pixel_scale
  import ws2812b_pkg::*;
(
  input  logic [PIXEL_W-1:0] pixel,
  input  logic [CHAN_W-1:0]  scale,
  output logic [PIXEL_W-1:0] scaled
);

  logic [CHAN_W:0] factor_s;

  // Factor is scale+1 so that full scale (255) becomes an exact pass-through
  always_comb begin
    factor_s             = {1'b0, scale} + 9'd1;
    scaled[G_HI:G_LO]    = scale_chan(pixel[G_HI:G_LO], factor_s);
    scaled[R_HI:R_LO]    = scale_chan(pixel[R_HI:R_LO], factor_s);
    scaled[B_HI:B_LO]    = scale_chan(pixel[B_HI:B_LO], factor_s);
  end

endmodule

// File: rtl/ws2812b_strip_ctrl.sv
// Frame sequencer for the ws2812b LED driver: holds the host-written pixel
// buffer and streams a frame of pixels over a valid/ready handshake, flagging
// the last one with drv_latch, then waits out the driver's reset gap.
// Optional feature macro: WS2812B_BRIGHTNESS_EN (adds a brightness input that
// scales every channel at LOAD time).
module ws2812b_strip_ctrl
  import ws2812b_pkg::*;
#(
  parameter int N_PIXELS = 16,
  parameter int AW       = $clog2(N_PIXELS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic [AW:0]        num_pixels,
  input  logic               start,
`ifdef WS2812B_BRIGHTNESS_EN
  input  logic [CHAN_W-1:0]  brightness,
`endif
  output logic               busy,
  output logic               done,
  output logic [PIXEL_W-1:0] drv_data,
  output logic               drv_valid,
  output logic               drv_latch,
  input  logic               drv_ready
);

  localparam logic [AW:0]   NPIX_L   = (AW+1)'(N_PIXELS);
  localparam logic [AW:0]   LEN_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   LEN_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};

  // Pixel buffer (intentionally not reset)
  logic [PIXEL_W-1:0] pix_buf_r [N_PIXELS];

  state_t             state_r, state_s;
  logic [AW-1:0]      idx_r, idx_s;
  logic [AW:0]        len_r, len_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic [PIXEL_W-1:0] drv_data_r, drv_data_s;
  logic               drv_valid_r, drv_valid_s;
  logic               drv_latch_r, drv_latch_s;

  logic               addr_ok_s;
  logic [AW:0]        len_clamp_s;
  logic [PIXEL_W-1:0] raw_pix_s;
  logic [PIXEL_W-1:0] load_pix_s;

  // Address range check and frame length clamp to the buffer depth
  always_comb begin
    addr_ok_s   = ({1'b0, wr_addr} < NPIX_L);
    len_clamp_s = (num_pixels > NPIX_L) ? NPIX_L : num_pixels;
    raw_pix_s   = pix_buf_r[idx_r];
  end

  // Host writes; a write coinciding with LOAD of the same address lands after the read
  always_ff @(posedge clk) begin
    if (wr_en && addr_ok_s) begin
      pix_buf_r[wr_addr] <= wr_data;
    end
  end

`ifdef WS2812B_BRIGHTNESS_EN
  logic [CHAN_W-1:0] brightness_r;

  // Brightness is frozen for the whole frame at the accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brightness_r <= 8'hFF;
    end else if ((state_r == IDLE) && start) begin
      brightness_r <= brightness;
    end
  end

  ws2812b_pixel_scale u_pixel_scale (
    .pixel  (raw_pix_s),
    .scale  (brightness_r),
    .scaled (load_pix_s)
  );
`else
  assign load_pix_s = raw_pix_s;
`endif

  // Next-state and next-output logic of the frame sequencer
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    len_s       = len_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    drv_data_s  = drv_data_r;
    drv_valid_s = drv_valid_r;
    drv_latch_s = drv_latch_r;

    case (state_r)
      IDLE: begin
        drv_valid_s = 1'b0;
        if (start) begin
          if (len_clamp_s != LEN_ZERO) begin
            len_s   = len_clamp_s;
            idx_s   = IDX_ZERO;
            busy_s  = 1'b1;
            state_s = LOAD;
          end else begin
            // Empty frame completes immediately without touching the driver
            done_s  = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end

      LOAD: begin
        drv_data_s  = load_pix_s;
        drv_latch_s = ({1'b0, idx_r} == (len_r - LEN_ONE));
        drv_valid_s = 1'b1;
        state_s     = SEND;
      end

      SEND: begin
        if (drv_ready && drv_valid_r) begin
          drv_valid_s = 1'b0;
          drv_latch_s = 1'b0;
          if (drv_latch_r) begin
            state_s = WAIT_LATCH;
          end else begin
            idx_s   = idx_r + IDX_ONE;
            state_s = LOAD;
          end
        end else begin
          state_s = SEND;
        end
      end

      WAIT_LATCH: begin
        // The driver raises ready again once its reset gap has elapsed
        drv_valid_s = 1'b0;
        if (drv_ready) begin
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          state_s = WAIT_LATCH;
        end
      end

      default: begin
        state_s     = IDLE;
        busy_s      = 1'b0;
        drv_valid_s = 1'b0;
        drv_latch_s = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      idx_r       <= IDX_ZERO;
      len_r       <= LEN_ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      drv_data_r  <= 24'h000000;
      drv_valid_r <= 1'b0;
      drv_latch_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      len_r       <= len_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      drv_data_r  <= drv_data_s;
      drv_valid_r <= drv_valid_s;
      drv_latch_r <= drv_latch_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign drv_data  = drv_data_r;
  assign drv_valid = drv_valid_r;
  assign drv_latch = drv_latch_r;

endmodule
